// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract unit with optional signed saturation.
// Works through the WIDTH-bit operands CHUNK bits per cycle and carries a
// registered carry from one chunk to the next. The unit has a valid/ready
// handshake on its input side and on its output side.
//
// States:
//   IDLE | in_ready=1, waiting for operands
//   CALC | one chunk per cycle, chunk index idx from 0 to NCHUNK-1
//   DONE | out_valid=1, result and flags held until out_ready
//
// Ports:
//   clk, rst_n            rising-edge clock, async active-low reset
//   in_valid, in_ready    input handshake (accepted only in IDLE)
//   a, b, op              operands; op: 00 add, 01 sub, 10 add-sat, 11 sub-sat
//   out_valid, out_ready  output handshake
//   result                sum or difference, saturated if op[1] is set
//   cout                  carry out of the MSB (for sub, 1 means no borrow)
//   ovf                   signed overflow of the unsaturated operation
//   zero, neg             taken from the final (possibly saturated) result
//
// WIDTH must be >= 2 and CHUNK must divide WIDTH.
module addsub_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;      // already inverted for subtraction
  logic             sat_r;    // op[1]; op[0] is folded into b_r and carry
  logic             carry;
  logic [IDXW-1:0]  idx;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] fin_res;
  logic             raw_ovf;

  always_comb begin
    chunk_sum = {1'b0, a_r[int'(idx)*CHUNK +: CHUNK]}
              + {1'b0, b_r[int'(idx)*CHUNK +: CHUNK]}
              + {{CHUNK{1'b0}}, carry};
    raw_res = result;
    raw_res[int'(idx)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    // Same-sign operands that give a different-sign sum. This is the same as
    // carry-in XOR carry-out at the MSB. It is only meaningful on the last chunk.
    raw_ovf = (a_r[WIDTH-1] ~^ b_r[WIDTH-1]) & (raw_res[WIDTH-1] ^ a_r[WIDTH-1]);
    fin_res = raw_res;
    if (sat_r && raw_ovf) begin
      fin_res = a_r[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                             : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      sat_r     <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= op[0] ? ~b : b;
            sat_r    <= op[1];
            carry    <= op[0];
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          carry <= chunk_sum[CHUNK];
          idx   <= idx + IDXW'(1);
          if (idx == LAST_IDX) begin
            result    <= fin_res;
            cout      <= chunk_sum[CHUNK];
            ovf       <= raw_ovf;
            zero      <= (fin_res == '0);
            neg       <= fin_res[WIDTH-1];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            result <= raw_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq.sv
// Runs four instances (CHUNK = 1, 4, 8, 16, WIDTH = 16) in lockstep on shared
// stimulus. Expected results go into a scoreboard queue when an op is driven,
// and are checked against every instance once all of them report out_valid.
module tb_addsub_seq;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic [1:0]  op;

  logic [3:0]  in_ready_w;
  logic [3:0]  out_valid_w;
  logic [15:0] result_w [4];
  logic [3:0]  cout_w;
  logic [3:0]  ovf_w;
  logic [3:0]  zero_w;
  logic [3:0]  neg_w;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int CH = (g == 0) ? 1 : (1 << (g + 1));
    addsub_seq #(.WIDTH(16), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .result    (result_w[g]),
      .cout      (cout_w[g]),
      .ovf       (ovf_w[g]),
      .zero      (zero_w[g]),
      .neg       (neg_w[g])
    );
  end

  function automatic int chunk_of(input int g);
    return (g == 0) ? 1 : (1 << (g + 1));
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: exact integer arithmetic, then wrap, then saturate.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o);
    exp_t        e;
    int          sx, sy, ex;
    logic [16:0] u;
    sx = int'($signed(x));
    sy = int'($signed(y));
    ex = o[0] ? (sx - sy) : (sx + sy);
    if (o[0]) begin
      e.r = x - y;
      e.c = (x >= y);
    end else begin
      u   = {1'b0, x} + {1'b0, y};
      e.r = u[15:0];
      e.c = u[16];
    end
    e.v = (ex > 32767) || (ex < -32768);
    if (o[1] && e.v) e.r = (ex > 0) ? 16'h7FFF : 16'h8000;
    e.z = (e.r == 16'h0000);
    e.n = e.r[15];
    return e;
  endfunction

  task automatic chk_outputs(input string tag, input exp_t e);
    for (int g = 0; g < 4; g++) begin
      chk_eq($sformatf("%s.result.c%0d", tag, chunk_of(g)), 32'(result_w[g]), 32'(e.r));
      chk_eq($sformatf("%s.cout.c%0d",   tag, chunk_of(g)), 32'(cout_w[g]),   32'(e.c));
      chk_eq($sformatf("%s.ovf.c%0d",    tag, chunk_of(g)), 32'(ovf_w[g]),    32'(e.v));
      chk_eq($sformatf("%s.zero.c%0d",   tag, chunk_of(g)), 32'(zero_w[g]),   32'(e.z));
      chk_eq($sformatf("%s.neg.c%0d",    tag, chunk_of(g)), 32'(neg_w[g]),    32'(e.n));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    exp_t z;
    z = '0;
    chk_eq({tag, ".in_ready"},  32'(in_ready_w),  32'hF);
    chk_eq({tag, ".out_valid"}, 32'(out_valid_w), 32'h0);
    chk_outputs(tag, z);
  endtask

  // Called about 1 time unit after a rising edge. Returns the same way,
  // just after the edge on which the op was accepted.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] o, input exp_t e);
    chk_eq("in_ready_before_op", 32'(in_ready_w), 32'hF);
    a = x; b = y; op = o; in_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done();
    int k;
    int lat [4];
    for (int g = 0; g < 4; g++) lat[g] = -1;
    k = 0;
    chk_eq("out_valid_at_accept", 32'(out_valid_w), 32'h0);
    while (out_valid_w != 4'hF && k < 100) begin
      @(posedge clk); #1;
      k++;
      for (int g = 0; g < 4; g++)
        if (out_valid_w[g] && lat[g] < 0) lat[g] = k;
    end
    if (k >= 100) chk_eq("timeout_out_valid", 32'(out_valid_w), 32'hF);
    for (int g = 0; g < 4; g++)
      chk_eq($sformatf("latency.c%0d", chunk_of(g)), 32'(lat[g]), 32'(16 / chunk_of(g)));
  endtask

  task automatic finish_op(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk_eq({tag, ".scoreboard_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk_outputs(tag, e);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk_eq({tag, ".in_ready_after"},  32'(in_ready_w),  32'hF);
    chk_eq({tag, ".out_valid_after"}, 32'(out_valid_w), 32'h0);
  endtask

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                        input logic [1:0] o, input exp_t e);
    start_op(x, y, o, e);
    wait_done();
    finish_op(tag);
  endtask

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [1:0]  o;
    exp_t        e;
  } vec_t;

  vec_t dir_tab [8];

  initial begin
    exp_t        e;
    logic [15:0] x, y;
    logic [1:0]  o;

    // Directed vectors with hand-computed results: {a, b, op, {r, c, v, z, n}}
    dir_tab[0] = '{16'h1234, 16'h0FFF, 2'b00, '{16'h2233, 1'b0, 1'b0, 1'b0, 1'b0}};
    dir_tab[1] = '{16'h0005, 16'h0007, 2'b01, '{16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1}};
    dir_tab[2] = '{16'hFFFF, 16'h0001, 2'b00, '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0}};
    dir_tab[3] = '{16'h7FFF, 16'h0001, 2'b00, '{16'h8000, 1'b0, 1'b1, 1'b0, 1'b1}};
    dir_tab[4] = '{16'h7FFF, 16'h0001, 2'b10, '{16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0}};
    dir_tab[5] = '{16'h8000, 16'h0001, 2'b11, '{16'h8000, 1'b1, 1'b1, 1'b0, 1'b1}};
    dir_tab[6] = '{16'h8000, 16'h0001, 2'b01, '{16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0}};
    dir_tab[7] = '{16'hABCD, 16'h1111, 2'b00, '{16'hBCDE, 1'b0, 1'b0, 1'b0, 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (dir_tab[i])
      run_op($sformatf("dir%0d", i), dir_tab[i].x, dir_tab[i].y, dir_tab[i].o, dir_tab[i].e);

    // Backpressure: hold the results for 10 cycles and pulse in_valid, which must be ignored.
    start_op(16'h1234, 16'h0FFF, 2'b00, dir_tab[0].e);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        a = 16'hDEAD; b = 16'hBEEF; op = 2'b01; in_valid = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk_outputs($sformatf("hold%0d", i), sb_q[0]);
      chk_eq($sformatf("hold%0d.in_ready", i),  32'(in_ready_w),  32'h0);
      chk_eq($sformatf("hold%0d.out_valid", i), 32'(out_valid_w), 32'hF);
    end
    finish_op("hold_release");
    run_op("after_hold", 16'h0005, 16'h0007, 2'b01, dir_tab[1].e);

    // Reset two cycles into CALC aborts the op. A fresh op after reset must be clean.
    start_op(16'h1234, 16'h0FFF, 2'b00, dir_tab[0].e);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_state("midreset");
    sb_q.delete();
    @(posedge clk); #1;
    chk_reset_state("midreset_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post_reset", 16'h7FFF, 16'h0001, 2'b10, dir_tab[4].e);

    // Random sweep with corner-value bias, checked against the reference model.
    for (int i = 0; i < 1000; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      o = 2'($urandom);
      case ($urandom_range(0, 7))
        0: x = 16'h7FFF;
        1: x = 16'h8000;
        2: y = 16'hFFFF;
        3: y = 16'h0000;
        4: y = x;
        default: ;
      endcase
      e = model(x, y, o);
      run_op($sformatf("rnd%0d", i), x, y, o, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
